// File: rtl/negate_share_arbiter.sv
// negate_share_arbiter
// Round-robin arbiter in front of one shared two's-complement negator.
// Holds a single registered result; a held result can be drained and
// replaced in the same cycle, so throughput is one result per clock.
module negate_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 25,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_ovf
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int unsigned NREQ_U = NREQ;

    state_t           state_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_ovf_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;

    logic             slot_free;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] operand_neg;
    logic             operand_ovf;
    logic             accept;

    // Output slot can take a new result when empty or being drained this cycle.
    // Held in reset, no lane sees ready, so no handshake can complete.
    assign slot_free = rst_n && ((state_q == EMPTY) || rsp_ready);

    // Round-robin search: first valid lane at or above rr_ptr, wrapping to 0
    always_comb begin
        int unsigned lane;
        grant_found = 1'b0;
        grant_idx   = '0;
        lane        = 0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            lane = (32'(rr_ptr_q) + k) % NREQ_U;
            if (!grant_found && req_valid[lane[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = lane[IDW-1:0];
            end
        end
    end

    // One-hot ready, operand mux and the combinational negator
    always_comb begin
        req_ready = '0;
        operand   = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (IDW'(i) == grant_idx) begin
                req_ready[i] = grant_found && slot_free;
                operand      = req_data[i*WIDTH +: WIDTH];
            end
        end
        operand_neg = ~operand + WIDTH'(1);
        operand_ovf = (operand == {1'b1, {(WIDTH-1){1'b0}}});
        rr_ptr_d    = (32'(grant_idx) == NREQ_U - 1) ? '0 : grant_idx + 1'b1;
    end

    assign accept = |req_ready;

    // Result FSM: accept loads (even while draining), drain without accept empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_ovf_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else if (accept) begin
            state_q     <= FULL;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= operand_neg;
            rsp_id_q    <= grant_idx;
            rsp_ovf_q   <= operand_ovf;
            rr_ptr_q    <= rr_ptr_d;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_q     <= EMPTY;
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_negate_share_arbiter.sv
// Testbench for negate_share_arbiter: directed scenarios plus randomized
// traffic checked against a queue-free behavioural model of the arbiter.
module tb_negate_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 25;
    localparam int IDW = 2;
    localparam longint unsigned MOD = 64'd1 << W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '1;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [W-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_ovf;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit               m_full;
    logic [W-1:0]     m_data;
    logic [IDW-1:0]   m_id;
    logic             m_ovf;
    int               m_ptr;
    logic [N-1:0]     exp_ready;
    int               cur_pick;
    logic [N*W-1:0]   cur_d;
    logic             cur_rr;

    negate_share_arbiter #(.NREQ(N), .WIDTH(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0; m_data = '0; m_id = '0; m_ovf = 1'b0; m_ptr = 0;
    endtask

    // drive inputs and predict the grant for the coming edge
    task automatic apply(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rr);
        int pick;
        req_valid = v; req_data = d; rsp_ready = rr;
        pick = model_pick(v, m_ptr);
        exp_ready = '0;
        cur_pick = -1;
        if ((!m_full || rr) && pick >= 0) begin
            exp_ready[pick] = 1'b1;
            cur_pick = pick;
        end
        cur_d = d; cur_rr = rr;
        #1;
    endtask

    // advance one clock and update the model from the predicted handshake
    task automatic tick();
        longint unsigned op;
        @(posedge clk);
        if (cur_pick >= 0) begin
            op     = longint'(cur_d[cur_pick*W +: W]);
            m_data = W'((MOD - op) % MOD);
            m_ovf  = (op == (MOD >> 1));
            m_id   = IDW'(cur_pick);
            m_ptr  = (cur_pick + 1) % N;
            m_full = 1;
        end else if (m_full && cur_rr) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 7))
                0:       d[i*W +: W] = '0;
                1:       d[i*W +: W] = W'(MOD >> 1);
                default: d[i*W +: W] = W'($urandom);
            endcase
        end
        return d;
    endfunction

    task automatic test_reset();
        model_reset();
        #3;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: req_ready=%b rsp_valid=%b expected 0000/0", req_ready, rsp_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h id=%0d ovf=%b expected all 0",
                     rsp_valid, rsp_data, rsp_id, rsp_ovf);
        end
    endtask

    task automatic test_single();
        logic [N*W-1:0] d;
        d = '0;
        d[W-1:0] = 25'h0000005;
        apply(4'b0001, d, 1'b1);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 25'h1FFFFFB || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b data=%h id=%0d ovf=%b expected 1/1fffffb/0/0",
                     rsp_valid, rsp_data, rsp_id, rsp_ovf);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(4'b1111, rand_data(), 1'b1);
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(i % N) || rsp_data !== m_data) begin
                errors++;
                $display("FAIL rr_seq[%0d]: valid=%b id=%0d data=%h expected 1/%0d/%h",
                         i, rsp_valid, rsp_id, rsp_data, i % N, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]   s_data;
        logic [IDW-1:0] s_id;
        logic           s_ovf;
        apply(4'b1111, rand_data(), 1'b1);
        tick();
        s_data = rsp_data; s_id = rsp_id; s_ovf = rsp_ovf;
        for (int i = 0; i < 3; i++) begin
            apply(4'b1111, rand_data(), 1'b0);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: req_ready=%b expected 0000", i, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== s_data || rsp_id !== s_id || rsp_ovf !== s_ovf) begin
                errors++;
                $display("FAIL bp_stable[%0d]: valid=%b data=%h id=%0d ovf=%b expected 1/%h/%0d/%b",
                         i, rsp_valid, rsp_data, rsp_id, rsp_ovf, s_data, s_id, s_ovf);
            end
        end
        apply(4'b1111, rand_data(), 1'b1);
        checks++;
        if (req_ready !== exp_ready || req_ready === 4'b0000) begin
            errors++;
            $display("FAIL bp_release: req_ready=%b expected %b", req_ready, exp_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_data !== m_data) begin
            errors++;
            $display("FAIL bp_refill: valid=%b id=%0d data=%h expected 1/%0d/%h",
                     rsp_valid, rsp_id, rsp_data, m_id, m_data);
        end
    endtask

    task automatic test_boundaries();
        logic [N*W-1:0] d;
        d = '0;
        d[W-1:0] = 25'h1000000;
        apply(4'b0001, d, 1'b1);
        tick();
        checks++;
        if (rsp_data !== 25'h1000000 || rsp_ovf !== 1'b1 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL bound_mostneg: data=%h ovf=%b id=%0d expected 1000000/1/0", rsp_data, rsp_ovf, rsp_id);
        end
        d = '0;
        d[2*W +: W] = 25'h0;
        apply(4'b0100, d, 1'b1);
        tick();
        checks++;
        if (rsp_data !== 25'h0 || rsp_ovf !== 1'b0 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL bound_zero: data=%h ovf=%b id=%0d expected 0000000/0/2", rsp_data, rsp_ovf, rsp_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        for (int i = 0; i < 300; i++) begin
            v = N'($urandom);
            apply(v, rand_data(), ($urandom_range(0, 9) < 7));
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d]: req_ready=%b expected %b", i, req_ready, exp_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'(m_full) || rsp_data !== m_data || rsp_id !== m_id || rsp_ovf !== m_ovf) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: valid=%b data=%h id=%0d ovf=%b expected %b/%h/%0d/%b",
                         i, rsp_valid, rsp_data, rsp_id, rsp_ovf, m_full, m_data, m_id, m_ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        // leave the pointer away from 0 with a result held
        apply(4'b0010, rand_data(), 1'b1);
        tick();
        apply(4'b1111, rand_data(), 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_data !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b req_ready=%b data=%h expected 0/0000/0",
                     rsp_valid, req_ready, rsp_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1111, rand_data(), 1'b1);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== m_data) begin
            errors++;
            $display("FAIL post_reset_rsp: valid=%b id=%0d data=%h expected 1/0/%h",
                     rsp_valid, rsp_id, rsp_data, m_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundaries();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
